// File: rtl/ngc_counter_bank.sv
// ngc_counter_bank: bank of N_CH independent up/down counters sharing one
// programmable prescaler tick. Each channel has its own bounds, step, load and
// mode (wrap, one-shot, ping-pong).
//
// Ports
//   clk              clock, all logic on posedge
//   rst              synchronous reset, active-low
//   prescale         shared tick every prescale+1 cycles
//   enb/load/dir     per-channel enable, load strobe, requested direction (1=up)
//   mode             per-channel 2 bits: 00 wrap, 01 one-shot, 10 ping-pong, 11 wrap
//   load_value       per-channel value written on load
//   count_from_value per-channel lower bound
//   count_to_value   per-channel upper bound
//   step_value       per-channel increment/decrement per tick
//   count            per-channel current count
//   count_hit        one-cycle pulse when a step reaches or crosses a bound
//   done             one-shot finished, held until load or reset
//   cur_dir          direction in use (ping-pong state)
module ngc_counter_bank #(
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned STEP_WIDTH     = COUNT_WIDTH / 2,
  parameter int unsigned N_CH           = 4,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic [N_CH-1:0]               enb,
  input  logic [N_CH-1:0]               load,
  input  logic [N_CH-1:0]               dir,
  input  logic [2*N_CH-1:0]             mode,
  input  logic [N_CH*COUNT_WIDTH-1:0]   load_value,
  input  logic [N_CH*COUNT_WIDTH-1:0]   count_from_value,
  input  logic [N_CH*COUNT_WIDTH-1:0]   count_to_value,
  input  logic [N_CH*STEP_WIDTH-1:0]    step_value,
  output logic [N_CH*COUNT_WIDTH-1:0]   count,
  output logic [N_CH-1:0]               count_hit,
  output logic [N_CH-1:0]               done,
  output logic [N_CH-1:0]               cur_dir
);

  // One extra bit so overflow and underflow (sign) are visible to the compares.
  localparam int unsigned AW = COUNT_WIDTH + 1;

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      tick;

  // Shared prescaler; a counter left above a newly lowered prescale wraps to 0.
  assign tick = (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (pre_cnt >= prescale) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [COUNT_WIDTH-1:0] lv;
    logic [COUNT_WIDTH-1:0] from_v;
    logic [COUNT_WIDTH-1:0] to_v;
    logic [STEP_WIDTH-1:0]  stp;
    logic [1:0]             md;
    logic                   pp;
    logic                   oneshot;
    logic                   use_up;
    logic                   step_en;
    logic                   hit;
    logic [AW-1:0]          nxt;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   hit_q;
    logic                   done_q;
    logic                   dir_q;

    assign lv      = load_value[i*COUNT_WIDTH +: COUNT_WIDTH];
    assign from_v  = count_from_value[i*COUNT_WIDTH +: COUNT_WIDTH];
    assign to_v    = count_to_value[i*COUNT_WIDTH +: COUNT_WIDTH];
    assign stp     = step_value[i*STEP_WIDTH +: STEP_WIDTH];
    assign md      = mode[2*i +: 2];
    assign pp      = (md == 2'b10);
    assign oneshot = (md == 2'b01);
    // Ping-pong follows its own direction state; other modes follow dir directly.
    assign use_up  = pp ? dir_q : dir[i];
    assign step_en = tick & enb[i] & ~done_q & (stp != '0);

    // Candidate next count and bound test; a negative result is a down hit.
    always_comb begin
      nxt = '0;
      hit = 1'b0;
      if (use_up) begin
        nxt = AW'(cnt_q) + AW'(stp);
        hit = (nxt >= AW'(to_v));
      end else begin
        nxt = AW'(cnt_q) - AW'(stp);
        hit = nxt[AW-1] | (nxt[COUNT_WIDTH-1:0] <= from_v);
      end
    end

    // Channel state: load > step > hold.
    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_q  <= '0;
        hit_q  <= 1'b0;
        done_q <= 1'b0;
        dir_q  <= 1'b1;
      end else if (load[i]) begin
        cnt_q  <= lv;
        hit_q  <= 1'b0;
        done_q <= 1'b0;
        dir_q  <= dir[i];
      end else begin
        hit_q <= 1'b0;
        if (!pp) begin
          dir_q <= dir[i];
        end
        if (step_en) begin
          if (!hit) begin
            cnt_q <= nxt[COUNT_WIDTH-1:0];
          end else begin
            hit_q <= 1'b1;
            if (pp) begin
              cnt_q <= use_up ? to_v : from_v;
              dir_q <= ~dir_q;
            end else if (oneshot) begin
              cnt_q  <= use_up ? to_v : from_v;
              done_q <= 1'b1;
            end else begin
              cnt_q <= use_up ? from_v : to_v;
            end
          end
        end
      end
    end

    assign count[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
    assign count_hit[i] = hit_q;
    assign done[i]      = done_q;
    assign cur_dir[i]   = dir_q;
  end

endmodule

// File: tb/tb_ngc_counter_bank.sv
// Testbench for ngc_counter_bank: directed vectors for the named corner cases
// plus randomized traffic compared against an integer reference model.
module tb_ngc_counter_bank;

  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned NC = 4;
  localparam int unsigned PW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [PW-1:0]     prescale;
  logic [NC-1:0]     enb;
  logic [NC-1:0]     load;
  logic [NC-1:0]     dir;
  logic [2*NC-1:0]   mode;
  logic [NC*CW-1:0]  load_value;
  logic [NC*CW-1:0]  count_from_value;
  logic [NC*CW-1:0]  count_to_value;
  logic [NC*SW-1:0]  step_value;
  logic [NC*CW-1:0]  count;
  logic [NC-1:0]     count_hit;
  logic [NC-1:0]     done;
  logic [NC-1:0]     cur_dir;

  always #5 clk = ~clk;

  ngc_counter_bank #(
    .COUNT_WIDTH(CW), .STEP_WIDTH(SW), .N_CH(NC), .PRESCALE_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .enb(enb), .load(load),
    .dir(dir), .mode(mode), .load_value(load_value),
    .count_from_value(count_from_value), .count_to_value(count_to_value),
    .step_value(step_value), .count(count), .count_hit(count_hit),
    .done(done), .cur_dir(cur_dir)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state, plain integers.
  int m_cnt[NC];
  int m_hit[NC];
  int m_done[NC];
  int m_dir[NC];
  int m_pc;

  typedef struct {
    logic       ld;
    logic       en;
    logic [7:0] lv;
    logic [7:0] exp_cnt;
    logic       exp_hit;
  } vec_t;

  vec_t tbl[8];
  int pp_cnt[7] = '{2, 4, 6, 4, 2, 0, 2};
  int pp_hit[7] = '{0, 0, 1, 0, 0, 1, 0};
  int pp_cd[7]  = '{1, 1, 0, 0, 0, 1, 1};
  int ps_cnt[8] = '{10, 10, 10, 11, 11, 11, 11, 12};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int ch);
    return int'(count[ch*CW +: CW]);
  endfunction

  task automatic cfg(input int ch, input int md, input int fr, input int to, input int st);
    mode[2*ch +: 2]              = 2'(md);
    count_from_value[ch*CW +: CW] = CW'(fr);
    count_to_value[ch*CW +: CW]   = CW'(to);
    step_value[ch*SW +: SW]       = SW'(st);
  endtask

  // Applies the counter rules to the inputs seen at this clock edge.
  task automatic model_step();
    int tk, n, up, h, fr, to, st, md, lv;
    tk = (m_pc == int'(prescale)) ? 1 : 0;
    if (!rst) m_pc = 0;
    else m_pc = (m_pc >= int'(prescale)) ? 0 : m_pc + 1;
    for (int i = 0; i < NC; i++) begin
      fr = int'(count_from_value[i*CW +: CW]);
      to = int'(count_to_value[i*CW +: CW]);
      st = int'(step_value[i*SW +: SW]);
      md = int'(mode[2*i +: 2]);
      lv = int'(load_value[i*CW +: CW]);
      assert (!rst || fr <= to) else $error("illegal bounds driven on channel %0d", i);
      if (!rst) begin
        m_cnt[i] = 0; m_hit[i] = 0; m_done[i] = 0; m_dir[i] = 1;
      end else if (load[i]) begin
        m_cnt[i] = lv; m_hit[i] = 0; m_done[i] = 0; m_dir[i] = int'(dir[i]);
      end else begin
        m_hit[i] = 0;
        up = (md == 2) ? m_dir[i] : int'(dir[i]);
        if (md != 2) m_dir[i] = int'(dir[i]);
        if (tk == 1 && enb[i] && m_done[i] == 0 && st != 0) begin
          n = (up == 1) ? m_cnt[i] + st : m_cnt[i] - st;
          h = (up == 1) ? ((n >= to) ? 1 : 0) : ((n <= fr) ? 1 : 0);
          if (h == 0) begin
            m_cnt[i] = n;
          end else begin
            m_hit[i] = 1;
            case (md)
              1: begin m_cnt[i] = (up == 1) ? to : fr; m_done[i] = 1; end
              2: begin m_cnt[i] = (up == 1) ? to : fr; m_dir[i] = 1 - up; end
              default: m_cnt[i] = (up == 1) ? fr : to;
            endcase
          end
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("model_count_ch%0d", i), cnt_of(i), m_cnt[i]);
      chk($sformatf("model_hit_ch%0d", i), int'(count_hit[i]), m_hit[i]);
      chk($sformatf("model_done_ch%0d", i), int'(done[i]), m_done[i]);
      chk($sformatf("model_dir_ch%0d", i), int'(cur_dir[i]), m_dir[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    int fr;
    m_pc = 0;
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_hit[i] = 0; m_done[i] = 0; m_dir[i] = 1;
    end
    rst = 1'b0; prescale = '0; enb = '0; load = '0; dir = '1; mode = '0;
    load_value = '0; count_from_value = '0; count_to_value = '0; step_value = '0;

    // Reset state
    step();
    step();
    chk("reset_count", (count == '0) ? 0 : 1, 0);
    chk("reset_hit", int'(count_hit), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cur_dir", int'(cur_dir), 15);
    rst = 1'b1;
    for (int i = 0; i < NC; i++) cfg(i, 0, 0, 255, 0);

    // Wrap up, table driven
    tbl[0] = '{1'b1, 1'b0, 8'd2, 8'd2, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'd0, 8'd5, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'd0, 8'd8, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'd0, 8'd2, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8'd0, 8'd5, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'd0, 8'd8, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'd0, 8'd2, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'd0, 8'd2, 1'b0};
    cfg(0, 0, 2, 10, 3);
    dir[0] = 1'b1;
    for (int r = 0; r < 8; r++) begin
      load[0] = tbl[r].ld;
      enb[0]  = tbl[r].en;
      load_value[7:0] = tbl[r].lv;
      step();
      chk($sformatf("wrap_count_row%0d", r), cnt_of(0), int'(tbl[r].exp_cnt));
      chk($sformatf("wrap_hit_row%0d", r), int'(count_hit[0]), int'(tbl[r].exp_hit));
    end
    load[0] = 1'b0; enb[0] = 1'b0;

    // One-shot down
    cfg(0, 1, 1, 15, 4);
    dir[0] = 1'b0; load[0] = 1'b1; load_value[7:0] = 8'd9;
    step();
    chk("os_load", cnt_of(0), 9);
    load[0] = 1'b0; enb[0] = 1'b1;
    step();
    chk("os_count1", cnt_of(0), 5);
    chk("os_hit1", int'(count_hit[0]), 0);
    step();
    chk("os_count2", cnt_of(0), 1);
    chk("os_hit2", int'(count_hit[0]), 1);
    chk("os_done2", int'(done[0]), 1);
    step();
    chk("os_hold_count", cnt_of(0), 1);
    chk("os_hold_hit", int'(count_hit[0]), 0);
    chk("os_hold_done", int'(done[0]), 1);
    chk("os_cur_dir", int'(cur_dir[0]), 0);
    load[0] = 1'b1; load_value[7:0] = 8'd7;
    step();
    chk("os_reload_count", cnt_of(0), 7);
    chk("os_reload_done", int'(done[0]), 0);
    load[0] = 1'b0; enb[0] = 1'b0;

    // Ping-pong; dir is flipped after load to show it is ignored
    cfg(0, 2, 0, 6, 2);
    dir[0] = 1'b1; load[0] = 1'b1; load_value[7:0] = 8'd0;
    step();
    chk("pp_load_count", cnt_of(0), 0);
    chk("pp_load_dir", int'(cur_dir[0]), 1);
    load[0] = 1'b0; dir[0] = 1'b0; enb[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("pp_count_%0d", k), cnt_of(0), pp_cnt[k]);
      chk($sformatf("pp_hit_%0d", k), int'(count_hit[0]), pp_hit[k]);
      chk($sformatf("pp_dir_%0d", k), int'(cur_dir[0]), pp_cd[k]);
    end
    enb[0] = 1'b0;

    // Prescale and load-over-step priority
    cfg(0, 0, 0, 13, 1);
    dir[0] = 1'b1; load[0] = 1'b1; load_value[7:0] = 8'd10;
    step();
    load[0] = 1'b0; prescale = 8'd3; enb[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("ps_count_%0d", k), cnt_of(0), ps_cnt[k]);
    end
    step(); step(); step();
    chk("ps_wait_count", cnt_of(0), 12);
    load[0] = 1'b1; load_value[7:0] = 8'd50;
    step();
    chk("prio_count", cnt_of(0), 50);
    chk("prio_hit", int'(count_hit[0]), 0);
    load[0] = 1'b0; enb[0] = 1'b0; prescale = 8'd0;

    // Overflow with concurrent ping-pong and one-shot channels
    cfg(0, 0, 0, 255, 15);
    cfg(1, 2, 0, 6, 2);
    cfg(2, 1, 0, 3, 4);
    dir[2:0] = 3'b111; load[2:0] = 3'b111;
    load_value[7:0] = 8'd250; load_value[15:8] = 8'd0; load_value[23:16] = 8'd0;
    step();
    chk("ovf_load", cnt_of(0), 250);
    load[2:0] = 3'b000; enb[2:0] = 3'b111;
    step();
    chk("ovf_count", cnt_of(0), 0);
    chk("ovf_hit", int'(count_hit[0]), 1);
    chk("mc_ch1_count", cnt_of(1), 2);
    chk("mc_ch1_hit", int'(count_hit[1]), 0);
    chk("mc_ch2_done", int'(done[2]), 1);
    step();
    chk("ovf_count2", cnt_of(0), 15);
    chk("mc_ch1_count2", cnt_of(1), 4);
    step_value[3:0] = 4'd0;
    step();
    chk("step0_count", cnt_of(0), 15);
    chk("step0_hit", int'(count_hit[0]), 0);
    chk("mc_ch1_hit3", int'(count_hit[1]), 1);
    chk("mc_ch1_dir3", int'(cur_dir[1]), 0);

    // Reset mid-count
    rst = 1'b0;
    step();
    chk("midrst_count", (count == '0) ? 0 : 1, 0);
    chk("midrst_hit", int'(count_hit), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cur_dir", int'(cur_dir), 15);
    step();
    chk("midrst_hold_ch1", cnt_of(1), 0);
    rst = 1'b1;
    step();
    chk("resume_ch1", cnt_of(1), 2);
    chk("resume_ch0", cnt_of(0), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) prescale = PW'($urandom_range(0, 3));
      enb = NC'($urandom);
      if ($urandom_range(0, 7) == 0) dir = NC'($urandom);
      for (int ch = 0; ch < NC; ch++) begin
        load[ch] = ($urandom_range(0, 7) == 0);
        load_value[ch*CW +: CW] = CW'($urandom);
        if ($urandom_range(0, 15) == 0) begin
          fr = int'($urandom_range(0, 200));
          cfg(ch, int'($urandom_range(0, 3)), fr, int'($urandom_range(fr, 255)),
              int'($urandom_range(0, 15)));
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
